// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_fifo_ctrl                                               |
// | Description : Single-clock FIFO controller that sequences a dual-port RAM  |
// |               (write port A, registered read port B) as a circular buffer. |
// |               Optional sticky overflow/underflow flags: FIFO_ERR_FLAG_EN.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module sync_fifo_ctrl #(
  parameter int ADDRSIZE = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_en,
  input  logic                i_rd_en,
`ifdef FIFO_ERR_FLAG_EN
  input  logic                i_err_clr,
  output logic                o_ovf_err,
  output logic                o_udf_err,
`endif
  output logic                o_full,
  output logic                o_empty,
  output logic                o_almost_full,
  output logic                o_almost_empty,
  output logic [ADDRSIZE:0]   o_count,
  output logic                o_rd_valid,
  output logic                o_ram_ena,
  output logic                o_ram_wea,
  output logic [ADDRSIZE-1:0] o_ram_addra,
  output logic                o_ram_enb,
  output logic [ADDRSIZE-1:0] o_ram_addrb
);

  localparam logic [ADDRSIZE:0] c_AF_LEVEL = (ADDRSIZE+1)'(AF_LEVEL);
  localparam logic [ADDRSIZE:0] c_AE_LEVEL = (ADDRSIZE+1)'(AE_LEVEL);

  logic [ADDRSIZE:0] r_wptr;
  logic [ADDRSIZE:0] r_rptr;
  logic              r_rd_valid;
  logic [ADDRSIZE:0] w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;

  // Flags decode from the registered pointers only; the wrap bit separates full from empty.
  assign w_count = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[ADDRSIZE] != r_rptr[ADDRSIZE]) &&
                   (r_wptr[ADDRSIZE-1:0] == r_rptr[ADDRSIZE-1:0]);

  // rst_n gating keeps the RAM strobes quiet while reset is held.
  assign w_wr_acc = i_wr_en & ~w_full & rst_n;
  assign w_rd_acc = i_rd_en & ~w_empty & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      r_rd_valid <= w_rd_acc;
    end
  end

`ifdef FIFO_ERR_FLAG_EN
  logic r_ovf_err;
  logic r_udf_err;

  // Set takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else begin
      if (i_wr_en && w_full)   r_ovf_err <= 1'b1;
      else if (i_err_clr)      r_ovf_err <= 1'b0;
      if (i_rd_en && w_empty)  r_udf_err <= 1'b1;
      else if (i_err_clr)      r_udf_err <= 1'b0;
    end
  end

  assign o_ovf_err = r_ovf_err;
  assign o_udf_err = r_udf_err;
`endif

  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_count        = w_count;
  assign o_almost_full  = (w_count >= c_AF_LEVEL);
  assign o_almost_empty = (w_count <= c_AE_LEVEL);
  assign o_rd_valid     = r_rd_valid;
  assign o_ram_ena      = w_wr_acc;
  assign o_ram_wea      = w_wr_acc;
  assign o_ram_addra    = r_wptr[ADDRSIZE-1:0];
  assign o_ram_enb      = w_rd_acc;
  assign o_ram_addrb    = r_rptr[ADDRSIZE-1:0];

endmodule
`default_nettype wire
